// File: rtl/modprod_arbiter.sv
// modprod_arbiter: two-requester round-robin front end for one shared ModuloProduct engine.
// Latches the winner's operands, runs the engine under a watchdog and returns the result to the owner.
`ifndef MAX_BITS
`define MAX_BITS 16
`endif

module modprod_arbiter #(
   parameter int WIDTH   = `MAX_BITS,
   parameter int TIMEOUT = 1023,
   parameter int TW      = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_n,
   input  logic             i_req0,
   input  logic [WIDTH-1:0] i_a0,
   input  logic [WIDTH-1:0] i_b0,
   input  logic             i_req1,
   input  logic [WIDTH-1:0] i_a1,
   input  logic [WIDTH-1:0] i_b1,
   output logic             o_gnt0,
   output logic             o_gnt1,
   output logic             o_done0,
   output logic             o_done1,
   output logic [WIDTH-1:0] o_result,
   output logic             o_busy,
   output logic             o_timeout,
   output logic             o_mp_start,
   output logic [WIDTH-1:0] o_mp_n,
   output logic [WIDTH-1:0] o_mp_a,
   output logic [WIDTH-1:0] o_mp_b,
   input  logic [WIDTH-1:0] i_mp_result,
   input  logic             i_mp_finished,
   output logic [1:0]       o_dbg_state
);

   // Handshake: a requester holds i_reqX and its operands until it sees the one-cycle o_gntX;
   // requests are only sampled in IDLE, and o_doneX marks the single cycle o_result is fresh.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;
   logic             mp_start_q, mp_start_d;
   logic [WIDTH-1:0] mp_a_q, mp_a_d;
   logic [WIDTH-1:0] mp_b_q, mp_b_d;

   logic             grant_vld;
   logic             grant_sel;
   logic             cnt_expired;

   // On a tie the requester that did not own the engine last goes first.
   assign grant_vld   = i_req0 | i_req1;
   assign grant_sel   = (i_req0 & i_req1) ? ~last_q : i_req1;
   assign cnt_expired = (cnt_q == TW'(TIMEOUT));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= '0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         mp_start_q <= 1'b0;
         mp_a_q     <= '0;
         mp_b_q     <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         result_q   <= result_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         mp_start_q <= mp_start_d;
         mp_a_q     <= mp_a_d;
         mp_b_q     <= mp_b_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               state_d = ST_START;
               owner_d = grant_sel;
               last_d  = grant_sel;
            end
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_mp_finished || cnt_expired) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      mp_start_d = 1'b0;
      result_d   = result_q;
      timeout_d  = timeout_q;
      mp_a_d     = mp_a_q;
      mp_b_d     = mp_b_q;
      cnt_d      = cnt_q;
      busy_d     = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               gnt0_d     = ~grant_sel;
               gnt1_d     = grant_sel;
               mp_start_d = 1'b1;
               mp_a_d     = grant_sel ? i_a1 : i_a0;
               mp_b_d     = grant_sel ? i_b1 : i_b0;
            end
         end
         ST_START: cnt_d = '0;
         ST_WAIT: begin
            // A finished pulse on the expiry cycle still delivers the real product.
            if (i_mp_finished) begin
               result_d = i_mp_result;
               done0_d  = ~owner_q;
               done1_d  = owner_q;
            end else if (cnt_expired) begin
               result_d  = '0;
               done0_d   = ~owner_q;
               done1_d   = owner_q;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         default: ;
      endcase
   end

   assign o_gnt0      = gnt0_q;
   assign o_gnt1      = gnt1_q;
   assign o_done0     = done0_q;
   assign o_done1     = done1_q;
   assign o_result    = result_q;
   assign o_busy      = busy_q;
   assign o_timeout   = timeout_q;
   assign o_mp_start  = mp_start_q;
   assign o_mp_n      = i_n;
   assign o_mp_a      = mp_a_q;
   assign o_mp_b      = mp_b_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_modprod_arbiter.sv
// Bench for modprod_arbiter: short-watchdog instance for most scenarios,
// default-watchdog instance for the mid-run reset scenario; both driven by a behavioural engine.
`timescale 1ns/1ps
module tb_modprod_arbiter;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] n_in;
   logic         req0 [2], req1 [2];
   logic [W-1:0] a0 [2], b0 [2], a1 [2], b1 [2];
   logic         gnt0 [2], gnt1 [2], done0 [2], done1 [2];
   logic [W-1:0] result [2];
   logic         busy [2], tmo [2], mp_start [2], mp_fin [2];
   logic [W-1:0] mp_n [2], mp_a [2], mp_b [2], eng_res [2];
   logic [1:0]   dbg [2];
   logic         eng_fin [2], eng_run [2], hang [2], spur [2];
   int           eng_cnt [2], lat [2];

   logic [W:0]   exp_q0[$];
   logic [W:0]   exp_q1[$];
   logic [W:0]   sb_exp, sb_got;

   modprod_arbiter #(.WIDTH(W), .TIMEOUT(20), .TW(10)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_n(n_in),
      .i_req0(req0[0]), .i_a0(a0[0]), .i_b0(b0[0]),
      .i_req1(req1[0]), .i_a1(a1[0]), .i_b1(b1[0]),
      .o_gnt0(gnt0[0]), .o_gnt1(gnt1[0]), .o_done0(done0[0]), .o_done1(done1[0]),
      .o_result(result[0]), .o_busy(busy[0]), .o_timeout(tmo[0]),
      .o_mp_start(mp_start[0]), .o_mp_n(mp_n[0]), .o_mp_a(mp_a[0]), .o_mp_b(mp_b[0]),
      .i_mp_result(eng_res[0]), .i_mp_finished(mp_fin[0]), .o_dbg_state(dbg[0])
   );

   modprod_arbiter #(.WIDTH(W)) u_long (
      .i_clk(clk), .i_rst(rst), .i_n(n_in),
      .i_req0(req0[1]), .i_a0(a0[1]), .i_b0(b0[1]),
      .i_req1(req1[1]), .i_a1(a1[1]), .i_b1(b1[1]),
      .o_gnt0(gnt0[1]), .o_gnt1(gnt1[1]), .o_done0(done0[1]), .o_done1(done1[1]),
      .o_result(result[1]), .o_busy(busy[1]), .o_timeout(tmo[1]),
      .o_mp_start(mp_start[1]), .o_mp_n(mp_n[1]), .o_mp_a(mp_a[1]), .o_mp_b(mp_b[1]),
      .i_mp_result(eng_res[1]), .i_mp_finished(mp_fin[1]), .o_dbg_state(dbg[1])
   );

   function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
      logic [2*W-1:0] p;
      if (m == '0) return '0;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return W'(p % {{W{1'b0}}, m});
   endfunction

   // Engine model: reads its operands live when it finishes, like the real shift-and-add unit.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            eng_run[k] <= 1'b0;
            eng_fin[k] <= 1'b0;
            eng_cnt[k] <= 0;
            eng_res[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            eng_fin[k] <= 1'b0;
            if (mp_start[k]) begin
               eng_run[k] <= !hang[k];
               eng_cnt[k] <= lat[k];
            end else if (eng_run[k]) begin
               if (eng_cnt[k] == 0) begin
                  eng_fin[k] <= 1'b1;
                  eng_res[k] <= modmul(mp_a[k], mp_b[k], mp_n[k]);
                  eng_run[k] <= 1'b0;
               end else begin
                  eng_cnt[k] <= eng_cnt[k] - 1;
               end
            end
         end
      end
   end

   assign mp_fin[0] = eng_fin[0] | spur[0];
   assign mp_fin[1] = eng_fin[1] | spur[1];

   // Scoreboard: every done pops one {owner, result} entry of its instance.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            if (gnt0[k] || gnt1[k]) begin
               n_checks++;
               if (gnt0[k] && gnt1[k]) begin
                  n_fails++;
                  $display("FAIL sb%0d_gnt_onehot: gnt0=1 gnt1=1, required at most one", k);
               end
            end
            if (done0[k] || done1[k]) begin
               n_checks++;
               if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                  n_fails++;
                  $display("FAIL sb%0d_unexpected_done: done0=%0b done1=%0b result=%0d, required no done",
                           k, done0[k], done1[k], result[k]);
               end else begin
                  if (k == 0) sb_exp = exp_q0.pop_front();
                  else        sb_exp = exp_q1.pop_front();
                  sb_got = {done1[k], result[k]};
                  if ((done0[k] && done1[k]) || sb_got !== sb_exp) begin
                     n_fails++;
                     $display("FAIL sb%0d_result: got done0=%0b done1=%0b result=%0d, required owner=%0d result=%0d",
                              k, done0[k], done1[k], result[k], sb_exp[W], sb_exp[W-1:0]);
                  end
               end
            end
         end
      end
   end

   task automatic apply_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req0[k] = 1'b0; req1[k] = 1'b0; spur[k] = 1'b0; hang[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_gnt(input int k, input int max_cyc, output logic ok, output logic g0, output logic g1);
      ok = 1'b0; g0 = 1'b0; g1 = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         if (gnt0[k] || gnt1[k]) begin
            ok = 1'b1; g0 = gnt0[k]; g1 = gnt1[k];
         end
      end
   endtask

   task automatic wait_done(input int k, input int max_cyc, output logic ok, output logic d0, output logic d1);
      ok = 1'b0; d0 = 1'b0; d1 = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         if (done0[k] || done1[k]) begin
            ok = 1'b1; d0 = done0[k]; d1 = done1[k];
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({gnt0[0], gnt1[0], done0[0], done1[0], busy[0], tmo[0], mp_start[0]} !== 7'b0 ||
          result[0] !== '0 || mp_a[0] !== '0 || mp_b[0] !== '0 || dbg[0] !== 2'd0) begin
         n_fails++;
         $display("FAIL reset_values: flags=%b result=%0d mp_a=%0d mp_b=%0d state=%0d, required all 0",
                  {gnt0[0], gnt1[0], done0[0], done1[0], busy[0], tmo[0], mp_start[0]},
                  result[0], mp_a[0], mp_b[0], dbg[0]);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      logic ok, g0, g1, d0, d1;
      int   starts, extra_gnt;
      logic busy_ok;
      n_in = 16'd13;
      @(posedge clk);
      #1 spur[0] = 1'b1;
      @(posedge clk);
      #1 spur[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (done0[0] || done1[0] || busy[0]) begin
         n_fails++;
         $display("FAIL idle_finished_ignored: done0=%0b done1=%0b busy=%0b, required 0 0 0",
                  done0[0], done1[0], busy[0]);
      end
      @(posedge clk);
      #1 a0[0] = 16'd5; b0[0] = 16'd7; lat[0] = 4; hang[0] = 1'b0;
      exp_q0.push_back({1'b0, 16'd9});
      req0[0] = 1'b1;
      wait_gnt(0, 10, ok, g0, g1);
      n_checks++;
      if (!ok || !g0 || g1 || !mp_start[0] || !busy[0] || mp_a[0] !== 16'd5 || mp_b[0] !== 16'd7) begin
         n_fails++;
         $display("FAIL single_grant: seen=%0b gnt0=%0b gnt1=%0b start=%0b busy=%0b mp_a=%0d mp_b=%0d, required 1 1 0 1 1 5 7",
                  ok, g0, g1, mp_start[0], busy[0], mp_a[0], mp_b[0]);
      end
      @(posedge clk);
      #1 req0[0] = 1'b0;
      starts = 1; extra_gnt = 0; busy_ok = 1'b1; ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (done0[0] || done1[0]) begin
            ok = 1'b1; d0 = done0[0]; d1 = done1[0];
         end else begin
            if (mp_start[0]) starts++;
            if (gnt0[0] || gnt1[0]) extra_gnt++;
            if (!busy[0]) busy_ok = 1'b0;
         end
      end
      n_checks++;
      if (!ok || !d0 || d1 || result[0] !== 16'd9 || busy[0]) begin
         n_fails++;
         $display("FAIL single_done: seen=%0b done0=%0b done1=%0b result=%0d busy=%0b, required 1 1 0 9 0",
                  ok, d0, d1, result[0], busy[0]);
      end
      n_checks++;
      if (starts != 1 || extra_gnt != 0 || !busy_ok) begin
         n_fails++;
         $display("FAIL single_pulses: starts=%0d extra_gnts=%0d busy_held=%0b, required 1 0 1",
                  starts, extra_gnt, busy_ok);
      end
   endtask

   task automatic test_tie();
      logic ok, g0, g1, d0, d1;
      int   t_done, t_gnt;
      apply_reset();
      n_in = 16'd11; lat[0] = 3;
      a0[0] = 16'd3; b0[0] = 16'd4; a1[0] = 16'd6; b1[0] = 16'd6;
      exp_q0.push_back({1'b0, 16'd1});
      exp_q0.push_back({1'b1, 16'd3});
      req0[0] = 1'b1; req1[0] = 1'b1;
      wait_gnt(0, 10, ok, g0, g1);
      n_checks++;
      if (!ok || !g0 || g1) begin
         n_fails++;
         $display("FAIL tie_first_grant: seen=%0b gnt0=%0b gnt1=%0b, required 1 1 0", ok, g0, g1);
      end
      @(posedge clk);
      #1 req0[0] = 1'b0;
      wait_done(0, 100, ok, d0, d1);
      t_done = cyc;
      n_checks++;
      if (!ok || !d0) begin
         n_fails++;
         $display("FAIL tie_done0: seen=%0b done0=%0b, required 1 1", ok, d0);
      end
      wait_gnt(0, 10, ok, g0, g1);
      t_gnt = cyc;
      n_checks++;
      if (!ok || !g1 || t_gnt != t_done + 1) begin
         n_fails++;
         $display("FAIL tie_second_grant: seen=%0b gnt1=%0b gnt_cycle=%0d, required 1 1 %0d",
                  ok, g1, t_gnt, t_done + 1);
      end
      @(posedge clk);
      #1 req1[0] = 1'b0;
      wait_done(0, 100, ok, d0, d1);
      n_checks++;
      if (!ok || !d1) begin
         n_fails++;
         $display("FAIL tie_done1: seen=%0b done1=%0b, required 1 1", ok, d1);
      end
   endtask

   task automatic test_fairness();
      logic ok, g0, g1;
      apply_reset();
      n_in = 16'd13; lat[0] = 2;
      a0[0] = 16'd10; b0[0] = 16'd3; a1[0] = 16'd7; b1[0] = 16'd12;
      exp_q0.push_back({1'b0, 16'd4});
      exp_q0.push_back({1'b1, 16'd6});
      exp_q0.push_back({1'b0, 16'd5});
      exp_q0.push_back({1'b1, 16'd3});
      req0[0] = 1'b1; req1[0] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         wait_gnt(0, 100, ok, g0, g1);
         n_checks++;
         if (!ok || g0 !== (j % 2 == 0) || g1 !== (j % 2 == 1)) begin
            n_fails++;
            $display("FAIL fair_order_job%0d: seen=%0b gnt0=%0b gnt1=%0b, required requester %0d",
                     j, ok, g0, g1, j % 2);
         end
         @(posedge clk);
         #1;
         case (j)
            0: begin a0[0] = 16'd4; b0[0] = 16'd11; end
            1: begin a1[0] = 16'd9; b1[0] = 16'd9; end
            2: req0[0] = 1'b0;
            default: req1[0] = 1'b0;
         endcase
      end
      for (int i = 0; i < 100 && exp_q0.size() != 0; i++) @(negedge clk);
      n_checks++;
      if (exp_q0.size() != 0) begin
         n_fails++;
         $display("FAIL fair_drain: pending=%0d, required 0", exp_q0.size());
      end
   endtask

   task automatic test_operand_hold();
      logic ok, g0, g1;
      n_in = 16'd13; lat[0] = 10;
      @(posedge clk);
      #1 a0[0] = 16'd6; b0[0] = 16'd5;
      exp_q0.push_back({1'b0, 16'd4});
      req0[0] = 1'b1;
      wait_gnt(0, 10, ok, g0, g1);
      n_checks++;
      if (!ok || !g0) begin
         n_fails++;
         $display("FAIL hold_grant: seen=%0b gnt0=%0b, required 1 1", ok, g0);
      end
      @(posedge clk);
      #1 a0[0] = '1; b0[0] = '1; req0[0] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (done0[0]) ok = 1'b1;
         n_checks++;
         if (mp_a[0] !== 16'd6 || mp_b[0] !== 16'd5) begin
            n_fails++;
            $display("FAIL hold_operands: mp_a=%0d mp_b=%0d, required 6 5", mp_a[0], mp_b[0]);
         end
      end
      n_checks++;
      if (!ok || result[0] !== 16'd4) begin
         n_fails++;
         $display("FAIL hold_done: seen=%0b result=%0d, required 1 4", ok, result[0]);
      end
   endtask

   task automatic test_timeout();
      logic ok, g0, g1, d0, d1;
      int   t_s, t_d;
      n_in = 16'd13; hang[0] = 1'b1; lat[0] = 3;
      @(posedge clk);
      #1 a0[0] = 16'd3; b0[0] = 16'd5;
      exp_q0.push_back({1'b0, 16'd0});
      req0[0] = 1'b1;
      wait_gnt(0, 10, ok, g0, g1);
      t_s = cyc;
      n_checks++;
      if (!ok || !g0 || !mp_start[0]) begin
         n_fails++;
         $display("FAIL timeout_grant: seen=%0b gnt0=%0b start=%0b, required 1 1 1", ok, g0, mp_start[0]);
      end
      @(posedge clk);
      #1 req0[0] = 1'b0;
      wait_done(0, 100, ok, d0, d1);
      t_d = cyc;
      n_checks++;
      if (!ok || !d0 || t_d - t_s != 22 || result[0] !== '0 || !tmo[0]) begin
         n_fails++;
         $display("FAIL timeout_abort: seen=%0b done0=%0b delay=%0d result=%0d timeout=%0b, required 1 1 22 0 1",
                  ok, d0, t_d - t_s, result[0], tmo[0]);
      end
      hang[0] = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (!tmo[0] || busy[0]) begin
         n_fails++;
         $display("FAIL timeout_sticky_idle: timeout=%0b busy=%0b, required 1 0", tmo[0], busy[0]);
      end
      @(posedge clk);
      #1 a0[0] = 16'd2; b0[0] = 16'd9;
      exp_q0.push_back({1'b0, 16'd5});
      req0[0] = 1'b1;
      wait_gnt(0, 10, ok, g0, g1);
      @(posedge clk);
      #1 req0[0] = 1'b0;
      wait_done(0, 100, ok, d0, d1);
      n_checks++;
      if (!ok || !d0 || result[0] !== 16'd5 || !tmo[0]) begin
         n_fails++;
         $display("FAIL timeout_next_job: seen=%0b done0=%0b result=%0d timeout=%0b, required 1 1 5 1",
                  ok, d0, result[0], tmo[0]);
      end
   endtask

   task automatic test_reset_wait();
      logic ok, g0, g1, d0, d1;
      logic any_done;
      n_in = 16'd13; lat[1] = 80; hang[1] = 1'b0;
      @(posedge clk);
      #1 a0[1] = 16'd7; b0[1] = 16'd8; req0[1] = 1'b1;
      wait_gnt(1, 10, ok, g0, g1);
      n_checks++;
      if (!ok || !g0) begin
         n_fails++;
         $display("FAIL rstwait_grant: seen=%0b gnt0=%0b, required 1 1", ok, g0);
      end
      @(posedge clk);
      #1 req0[1] = 1'b0;
      repeat (49) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (!busy[1] || dbg[1] !== 2'd2) begin
         n_fails++;
         $display("FAIL rstwait_running: busy=%0b state=%0d, required 1 2", busy[1], dbg[1]);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({gnt0[1], gnt1[1], done0[1], done1[1], busy[1], tmo[1], mp_start[1]} !== 7'b0 ||
          result[1] !== '0 || mp_a[1] !== '0 || mp_b[1] !== '0 || dbg[1] !== 2'd0) begin
         n_fails++;
         $display("FAIL rstwait_immediate: flags=%b result=%0d mp_a=%0d mp_b=%0d state=%0d, required all 0",
                  {gnt0[1], gnt1[1], done0[1], done1[1], busy[1], tmo[1], mp_start[1]},
                  result[1], mp_a[1], mp_b[1], dbg[1]);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      any_done = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (done0[1] || done1[1]) any_done = 1'b1;
      end
      n_checks++;
      if (any_done) begin
         n_fails++;
         $display("FAIL rstwait_no_done: done seen=1, required 0");
      end
      lat[1] = 6;
      @(posedge clk);
      #1 a0[1] = 16'd9; b0[1] = 16'd3;
      exp_q1.push_back({1'b0, 16'd1});
      req0[1] = 1'b1;
      wait_gnt(1, 10, ok, g0, g1);
      @(posedge clk);
      #1 req0[1] = 1'b0;
      wait_done(1, 100, ok, d0, d1);
      n_checks++;
      if (!ok || !d0 || result[1] !== 16'd1) begin
         n_fails++;
         $display("FAIL rstwait_after: seen=%0b done0=%0b result=%0d, required 1 1 1", ok, d0, result[1]);
      end
   endtask

   initial begin
      rst = 1'b1;
      n_in = '0;
      for (int k = 0; k < 2; k++) begin
         req0[k] = 1'b0; req1[k] = 1'b0;
         a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
         hang[k] = 1'b0; spur[k] = 1'b0; lat[k] = 3;
      end
      test_reset();
      test_single();
      test_tie();
      test_fairness();
      test_operand_hold();
      test_timeout();
      test_reset_wait();
      repeat (5) @(negedge clk);
      n_checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         n_fails++;
         $display("FAIL sb_drain: pending0=%0d pending1=%0d, required 0 0", exp_q0.size(), exp_q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/modprod_arbiter.md
Name: modprod_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for a single shared ModuloProduct engine (shift-and-add modular multiply, a*b mod n).
- Latches the winning requester's operands and holds them stable for the whole engine run, since the engine reads its multiplier bits live.
- Pulses the engine start and waits for its finished pulse. Returns the result to the owner with a done pulse.
- Sits between the ECC point-add/point-double controllers and the one multiplier instance.

Parameters:
- WIDTH, `MAX_BITS, operand/result width.
- TIMEOUT, 1023, max WAIT cycles before the job is aborted.
- TW, 10, width of timeout counter; must hold TIMEOUT.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_n  in  WIDTH  modulus, shared by both requesters, held stable by system.
- i_req0  in  1  requester 0 request level.
- i_a0  in  WIDTH  requester 0 multiplier.
- i_b0  in  WIDTH  requester 0 multiplicand.
- i_req1  in  1  requester 1 request level.
- i_a1  in  WIDTH  requester 1 multiplier.
- i_b1  in  WIDTH  requester 1 multiplicand.
- o_gnt0  out  1  one-cycle grant pulse, requester 0.
- o_gnt1  out  1  one-cycle grant pulse, requester 1.
- o_done0  out  1  one-cycle done pulse, requester 0.
- o_done1  out  1  one-cycle done pulse, requester 1.
- o_result  out  WIDTH  product; valid while o_doneX=1; holds until next done.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  sticky; set on abort, cleared only by reset.
- o_mp_start  out  1  engine start pulse.
- o_mp_n  out  WIDTH  engine modulus; wired to i_n.
- o_mp_a  out  WIDTH  engine multiplier; registered.
- o_mp_b  out  WIDTH  engine multiplicand; registered.
- i_mp_result  in  WIDTH  engine result.
- i_mp_finished  in  1  engine one-cycle finished pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; last-owner pointer = 1, so requester 0 wins the first tie; timeout counter 0.
- All outputs except o_mp_n are registered.
- FSM states:
  - IDLE: i_req0/i_req1 are sampled only in this state.
    - One request: grant it.
    - Both requests: grant the requester not equal to the last owner.
    - On a grant: latch a/b into o_mp_a/o_mp_b, record the owner, update the last-owner pointer, o_gntX=1 next cycle, go to START.
  - START: o_mp_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - On i_mp_finished=1: o_result <= i_mp_result, o_done(owner)=1 next cycle, go to IDLE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT: o_result <= 0, o_done(owner)=1, o_timeout <= 1, go to IDLE.
- Requester rules:
  - Hold i_req and operands stable until o_gntX is seen.
  - Deassert i_req in the o_gntX cycle unless another job is wanted.
  - Operands may change freely after the grant.
- Timing:
  - A request sampled in IDLE at cycle t gives o_gntX at t+1 and o_mp_start at t+1.
  - Engine finished at cycle f gives o_doneX at f+1.
  - The done cycle is an IDLE cycle, so a new request can be sampled in it; back-to-back jobs have no bubble beyond this.
- Stability: o_mp_a and o_mp_b change only on a grant, so they are constant from start through finished.
- i_mp_finished outside WAIT is ignored.
- At most one o_gnt and one o_done are high in any cycle. A done and a grant for different requesters may not coincide, because a grant needs the IDLE sample that follows the done.
- Reset mid-operation: immediate return to reset values, no done pulse for the aborted job; the engine shares i_rst and also resets.
- Width: no arithmetic beyond counter increment; counter saturates at TIMEOUT.

Test Plan:
- Single job: n=13, req0 with a=5, b=7. Required: one o_gnt0 pulse, exactly one o_mp_start pulse, o_done0 with o_result=9; o_gnt1/o_done1 stay 0; o_busy high from gnt through the finished cycle.
- Tie after reset: n=11; req0 a=3 b=4 and req1 a=6 b=6 asserted in the same cycle. Required: requester 0 served first with result 1, then requester 1 with result 3; o_done0 precedes o_gnt1.
- Fairness: both requests held high for 4 jobs. Required grant order 0,1,0,1; each result correct.
- Operand hold: after o_gnt0, drive i_a0=all-ones mid-run. Required: o_mp_a unchanged until o_done0; result still equals the original a*b mod n.
- Timeout: engine model never pulses finished, TIMEOUT=20. Required: o_done0 exactly 22 cycles after o_mp_start, o_result=0, o_timeout=1 and sticky; the next job (n=13, a=2, b=9) is served normally with result 5.
- Reset in WAIT: assert i_rst 50 cycles into a job. Required: all outputs 0 immediately, no done pulse; a post-reset request completes correctly.
